// File: rtl/modular_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : modular_operand_stage
// Description : Second stage of the pipelined modular adder/subtractor.
//               Accepts operand pairs (a, b) and an op select s over a
//               valid/ready handshake. It produces the raw result
//               v = a op b and the corrected result w = v -/+ m, together
//               with the flags the downstream selector needs (b4, b4_0)
//               and an operand range error flag. The modulus m is held in
//               a local register. The pipeline has two register stages
//               (capture, compute) and sustains one beat per clock.
//
//               Ports
//                 clk, rst_n         clock, synchronous active-low reset
//                 m_load, m_in       modulus load (honoured only when idle)
//                 m_ok               modulus register holds m >= 2
//                 in_valid/in_ready  operand handshake (in_s, in_a, in_b)
//                 out_valid/out_ready result handshake
//                 out_s, out_v, out_w, out_b4, out_b4_0, out_err
//                 busy               any stage holds a valid beat
// Revision    : 1.0 - initial release
// ============================================================================
module modular_operand_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         m_load,
    input  logic [N-1:0] m_in,
    output logic         m_ok,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_s,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_s,
    output logic [N:0]   out_v,
    output logic [N:0]   out_w,
    output logic         out_b4,
    output logic         out_b4_0,
    output logic         out_err,
    output logic         busy
);

    localparam int c_W = N + 1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [N-1:0]   r_m_q;

    logic           r_st1_valid;
    logic           r_st1_s;
    logic [N-1:0]   r_st1_a;
    logic [N-1:0]   r_st1_b;
    logic           r_st1_err;

    logic           r_st2_valid;
    logic           r_st2_s;
    logic [c_W-1:0] r_st2_v;
    logic [c_W-1:0] r_st2_w;
    logic           r_st2_b4;
    logic           r_st2_b4_0;
    logic           r_st2_err;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_st2_accept;
    logic w_st1_accept;
    logic w_in_fire;
    logic w_m_load_ok;
    logic w_in_err;

    assign busy         = r_st1_valid | r_st2_valid;
    // m >= 2 exactly when some bit above bit 0 is set.
    assign m_ok         = |r_m_q[N-1:1];

    assign w_st2_accept = ~r_st2_valid | out_ready;
    assign w_st1_accept = ~r_st1_valid | w_st2_accept;
    // in_ready never looks at in_valid; a pending m_load blocks new beats
    // so a load request and an operand cannot race each other.
    assign in_ready     = w_st1_accept & m_ok & ~m_load;
    assign w_in_fire    = in_valid & in_ready;

    // A load is only safe with nothing in flight and nothing being offered,
    // so every beat sees one consistent modulus from capture to compute.
    assign w_m_load_ok  = m_load & ~busy & ~in_valid;

    assign w_in_err     = (in_a >= r_m_q) | (in_b >= r_m_q);

    // ------------------------------------------------------------------
    // Stage 2 arithmetic (mod 2^(N+1), operands zero-extended)
    // ------------------------------------------------------------------
    logic [c_W-1:0] w_a_ext;
    logic [c_W-1:0] w_b_ext;
    logic [c_W-1:0] w_m_ext;
    logic [c_W-1:0] w_m_neg;
    logic [c_W-1:0] w_v;
    logic [c_W-1:0] w_corr;
    logic [c_W:0]   w_sum;

    assign w_a_ext = {1'b0, r_st1_a};
    assign w_b_ext = {1'b0, r_st1_b};
    assign w_m_ext = {1'b0, r_m_q};
    // Two's complement of m, i.e. 2^(N+1) - m.
    assign w_m_neg = (~w_m_ext) + {{N{1'b0}}, 1'b1};

    assign w_v     = r_st1_s ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
    // Add: try v - m. Subtract: try v + m (undo a negative difference).
    assign w_corr  = r_st1_s ? w_m_ext : w_m_neg;
    // One extra bit so the carry out of bit N becomes b4_0.
    assign w_sum   = {1'b0, w_v} + {1'b0, w_corr};

    // ------------------------------------------------------------------
    // Modulus register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_q <= '0;
        end else if (w_m_load_ok) begin
            r_m_q <= m_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st1_valid <= 1'b0;
            r_st1_s     <= 1'b0;
            r_st1_a     <= '0;
            r_st1_b     <= '0;
            r_st1_err   <= 1'b0;
        end else if (w_st1_accept) begin
            r_st1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_st1_s   <= in_s;
                r_st1_a   <= in_a;
                r_st1_b   <= in_b;
                r_st1_err <= w_in_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: compute. Holds still while the downstream stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st2_valid <= 1'b0;
            r_st2_s     <= 1'b0;
            r_st2_v     <= '0;
            r_st2_w     <= '0;
            r_st2_b4    <= 1'b0;
            r_st2_b4_0  <= 1'b0;
            r_st2_err   <= 1'b0;
        end else if (w_st2_accept) begin
            r_st2_valid <= r_st1_valid;
            if (r_st1_valid) begin
                r_st2_s    <= r_st1_s;
                r_st2_v    <= w_v;
                r_st2_w    <= w_sum[c_W-1:0];
                r_st2_b4   <= w_corr[N];
                r_st2_b4_0 <= w_sum[c_W];
                r_st2_err  <= r_st1_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = r_st2_valid;
    assign out_s     = r_st2_s;
    assign out_v     = r_st2_v;
    assign out_w     = r_st2_w;
    assign out_b4    = r_st2_b4;
    assign out_b4_0  = r_st2_b4_0;
    assign out_err   = r_st2_err;

endmodule
`default_nettype wire

// File: tb/tb_modular_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_modular_operand_stage
// Description : Self-checking bench for modular_operand_stage (N = 4).
//               Expected beats are queued when an operand is accepted and
//               compared when the DUT hands a result downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modular_operand_stage;

    typedef struct packed {
        logic       s;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] m;
        logic [4:0] v;
        logic [4:0] w;
        logic       b4;
        logic       b4_0;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_load;
    logic [3:0] m_in;
    logic       m_ok;
    logic       in_valid;
    logic       in_ready;
    logic       in_s;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic       out_s;
    logic [4:0] out_v;
    logic [4:0] out_w;
    logic       out_b4;
    logic       out_b4_0;
    logic       out_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t sb[$];
    vec_t tbl[11];

    modular_operand_stage #(.N(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_load   (m_load),
        .m_in     (m_in),
        .m_ok     (m_ok),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_s     (in_s),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s    (out_s),
        .out_v    (out_v),
        .out_w    (out_w),
        .out_b4   (out_b4),
        .out_b4_0 (out_b4_0),
        .out_err  (out_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] m, input logic [4:0] v, input logic [4:0] w,
                                input logic b4, input logic b4_0, input logic err);
        vec_t e;
        e.s = s; e.a = a; e.b = b; e.m = m; e.v = v; e.w = w;
        e.b4 = b4; e.b4_0 = b4_0; e.err = err;
        return e;
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic vec_t model(input logic s, input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] m);
        vec_t e;
        int vi, ci, t;
        vi = s ? ((int'(a) - int'(b) + 32) % 32) : (int'(a) + int'(b));
        ci = s ? int'(m) : ((32 - int'(m)) % 32);
        t  = vi + ci;
        e.s = s; e.a = a; e.b = b; e.m = m;
        e.v    = 5'(vi);
        e.w    = 5'(t % 32);
        e.b4   = (ci >= 16);
        e.b4_0 = (t >= 32);
        e.err  = (a >= m) || (b >= m);
        return e;
    endfunction

    // Called at posedge+1; offers one beat, returns at posedge+1 after it is taken.
    task automatic drive(input vec_t e);
        bit taken = 0;
        in_valid = 1'b1;
        in_s = e.s; in_a = e.a; in_b = e.b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                taken = 1;
                break;
            end
        end
        if (!taken) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: actual=0 required=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("drain_busy", {31'b0, busy}, 0);
        check("drain_queue", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic load_m(input logic [3:0] val);
        m_load = 1'b1;
        m_in   = val;
        @(posedge clk); #1;
        m_load = 1'b0;
    endtask

    // ---------------- Monitor / scoreboard ----------------
    bit          prev_stall = 0;
    logic [13:0] held;
    vec_t        exp_e;
    logic [4:0]  sel;
    int          exp_sel;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("stall_hold", {17'b0, out_valid, out_s, out_v, out_w, out_b4, out_b4_0, out_err},
                      {17'b0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_beat", {31'b0, out_valid}, 0);
                end else begin
                    exp_e = sb.pop_front();
                    check("beat", {out_s, out_v, out_w, out_b4, out_b4_0, out_err},
                          {exp_e.s, exp_e.v, exp_e.w, exp_e.b4, exp_e.b4_0, exp_e.err});
                    if (!exp_e.err) begin
                        if (exp_e.s) sel = out_v[4] ? out_w : out_v;
                        else         sel = out_b4_0 ? out_w : out_v;
                        if (exp_e.s) exp_sel = (int'(exp_e.a) - int'(exp_e.b) + int'(exp_e.m)) % int'(exp_e.m);
                        else         exp_sel = (int'(exp_e.a) + int'(exp_e.b)) % int'(exp_e.m);
                        check("select", {27'b0, sel}, exp_sel);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            held = {out_s, out_v, out_w, out_b4, out_b4_0, out_err};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    initial begin
        tbl[0]  = mk(0, 4'd7,  4'd9,  4'd13, 5'b10000, 5'b00011, 1, 1, 0);
        tbl[1]  = mk(1, 4'd3,  4'd9,  4'd13, 5'b11010, 5'b00111, 0, 1, 0);
        tbl[2]  = mk(0, 4'd2,  4'd3,  4'd13, 5'b00101, 5'b11000, 1, 0, 0);
        tbl[3]  = mk(0, 4'd12, 4'd12, 4'd13, 5'd24,    5'd11,    1, 1, 0);
        tbl[4]  = mk(1, 4'd9,  4'd3,  4'd13, 5'd6,     5'd19,    0, 0, 0);
        tbl[5]  = mk(1, 4'd0,  4'd12, 4'd13, 5'd20,    5'd1,     0, 1, 0);
        tbl[6]  = mk(0, 4'd0,  4'd0,  4'd13, 5'd0,     5'd19,    1, 0, 0);
        tbl[7]  = mk(0, 4'd15, 4'd14, 4'd13, 5'd29,    5'd16,    1, 1, 1);
        tbl[8]  = mk(1, 4'd5,  4'd5,  4'd13, 5'd0,     5'd13,    0, 0, 0);
        tbl[9]  = mk(0, 4'd13, 4'd0,  4'd13, 5'd13,    5'd0,     1, 1, 1);
        tbl[10] = mk(1, 4'd0,  4'd15, 4'd13, 5'd17,    5'd30,    0, 0, 1);

        rst_n = 1'b0; m_load = 1'b0; m_in = '0;
        in_valid = 1'b0; in_s = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_vw",    {22'b0, out_v, out_w}, 0);
        check("rst_m_ok",      {31'b0, m_ok}, 0);
        check("rst_busy",      {31'b0, busy}, 0);
        check("rst_in_ready",  {31'b0, in_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load m = 13
        load_m(4'd13);
        @(negedge clk);
        check("m13_ok",       {31'b0, m_ok}, 1);
        check("m13_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;

        // Table vectors, back to back
        for (int i = 0; i < 11; i++) drive(tbl[i]);
        wait_idle();

        // Latency: out_valid appears on the second negedge after the accept edge
        drive(tbl[0]);
        @(negedge clk);
        check("latency_st1", {31'b0, out_valid}, 0);
        @(negedge clk);
        check("latency_st2", {31'b0, out_valid}, 1);
        @(posedge clk); #1;
        wait_idle();

        // Backpressure stream of 8 beats, out_ready low for 4 cycles
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [3:0] ra, rb;
                    logic       rs;
                    ra = 4'($urandom_range(0, 12));
                    rb = 4'($urandom_range(0, 12));
                    rs = 1'($urandom_range(0, 1));
                    drive(model(rs, ra, rb, 4'd13));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", {31'b0, in_ready}, 0);
                check("stall_out_valid", {31'b0, out_valid}, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("full_pipe_in_ready", {31'b0, in_ready}, 1);
                check("full_pipe_busy", {31'b0, busy}, 1);
            end
        join
        wait_idle();

        // m_load while busy is ignored
        drive(model(0, 4'd9, 4'd5, 4'd13));
        load_m(4'd11);
        wait_idle();
        drive(mk(0, 4'd9, 4'd5, 4'd13, 5'd14, 5'd1, 1, 1, 0));
        wait_idle();

        // Reload m = 11 while idle
        load_m(4'd11);
        drive(mk(0, 4'd9, 4'd5, 4'd11, 5'd14, 5'b00011, 1, 1, 0));
        wait_idle();

        // m = 1 is not usable
        load_m(4'd1);
        @(negedge clk);
        check("m1_ok",       {31'b0, m_ok}, 0);
        check("m1_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk); #1;

        // Reset with two beats in flight
        load_m(4'd13);
        drive(tbl[2]);
        drive(tbl[3]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid}, 0);
        check("midrst_m_ok",      {31'b0, m_ok}, 0);
        check("midrst_busy",      {31'b0, busy}, 0);
        repeat (4) @(negedge clk);
        check("midrst_quiet", {31'b0, out_valid}, 0);
        @(posedge clk); #1;
        load_m(4'd13);
        drive(tbl[1]);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
